// File: rtl/agc_pkg.sv
// agc_pkg: shared widths, state/direction types and helpers for the AGC step controller.
package agc_pkg;
  localparam int ATT_W  = 6;
  localparam int PWR_W  = 32;
  localparam int HYST_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, MONITOR = 2'd1, UPDATE = 2'd2, SETTLE = 2'd3} agc_state_e;
  typedef enum logic {INC = 1'b0, DEC = 1'b1} agc_dir_e;
  function automatic logic [HYST_W-1:0] sat_inc(input logic [HYST_W-1:0] c);
    return &c ? c : c + HYST_W'(1);
  endfunction
endpackage

// File: rtl/agc_settle_timer.sv
// agc_settle_timer: loadable down-counter; busy while counting, done on the last busy cycle.
module agc_settle_timer #(
  parameter int CNT = 36864
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);
  localparam int W = $clog2(CNT + 1);
  logic [W-1:0] cnt;
  assign busy = cnt != '0;
  assign done = cnt == W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= start ? W'(CNT) : busy ? cnt - W'(1) : cnt;
endmodule

// File: rtl/agc_step_ctrl.sv
// agc_step_ctrl: AGC attenuation step controller with hysteresis, ceiling clamp and settle hold.
// Define AGC_FAST_ATTACK_EN for a +2 dB step on peaks above twice the high gate.
module agc_step_ctrl
  import agc_pkg::*;
#(
  parameter int SETTLE_CNT = 36864,
  parameter int ATTACK_N   = 1,
  parameter int RELEASE_N  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_agc_en,
  input  logic             i_meas_vld,
  input  logic [PWR_W-1:0] i_power_peak,
  input  logic [PWR_W-1:0] i_high_gate,
  input  logic [PWR_W-1:0] i_low_gate,
  input  logic [ATT_W-1:0] i_max_att,
  input  logic             i_mcu_clr,
  output logic [ATT_W-1:0] o_agc_value,
  output logic             o_att_inc,
  output logic             o_att_dec,
  output logic             o_hold,
  output logic [1:0]       o_state
);
  agc_state_e state, next_state;
  agc_dir_e dir, next_dir;
  logic [HYST_W-1:0] hi_cnt, lo_cnt, next_hi, next_lo;
  logic [ATT_W-1:0] next_value;
  logic step, over, under, settle_start, settle_busy, settle_done;
`ifdef AGC_FAST_ATTACK_EN
  logic fast, next_fast, fast_hit;
  assign fast_hit = {1'b0, i_power_peak} > {i_high_gate, 1'b0};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) fast <= 1'b0;
    else fast <= next_fast;
`endif
  assign over = i_power_peak > i_high_gate;
  assign under = i_power_peak < i_low_gate;
  // a clear while already settling restarts the hold period
  assign settle_start = next_state == SETTLE && (state != SETTLE || i_mcu_clr);
  assign o_state = state;
  agc_settle_timer #(.CNT(SETTLE_CNT)) u_timer (
    .clk(i_clk), .rst_n(i_rst_n), .start(settle_start), .busy(settle_busy), .done(settle_done)
  );
  always_comb begin
    next_state = state;
    next_dir = dir;
    next_hi = '0;
    next_lo = '0;
    next_value = o_agc_value;
    step = 1'b0;
`ifdef AGC_FAST_ATTACK_EN
    next_fast = 1'b0;
`endif
    if (i_mcu_clr) begin
      next_state = i_agc_en ? SETTLE : IDLE;
      next_value = '0;
    end else if (!i_agc_en) next_state = IDLE;
    else case (state)
      IDLE: next_state = MONITOR;
      MONITOR: begin
        next_hi = hi_cnt;
        next_lo = lo_cnt;
        if (i_max_att < o_agc_value) begin
          next_state = UPDATE;
          next_dir = DEC;
        end else if (hi_cnt == HYST_W'(ATTACK_N) && o_agc_value < i_max_att) begin
          next_state = UPDATE;
          next_dir = INC;
        end else if (lo_cnt == HYST_W'(RELEASE_N) && o_agc_value != '0) begin
          next_state = UPDATE;
          next_dir = DEC;
        end
`ifdef AGC_FAST_ATTACK_EN
        else if (i_meas_vld && fast_hit && o_agc_value < i_max_att) begin
          next_state = UPDATE;
          next_dir = INC;
          next_fast = 1'b1;
        end
`endif
        else if (i_meas_vld) begin
          next_hi = over ? sat_inc(hi_cnt) : '0;
          next_lo = !over && under ? sat_inc(lo_cnt) : '0;
        end
      end
      UPDATE: begin
        step = 1'b1;
        next_value = dir == INC ? o_agc_value + ATT_W'(1) : o_agc_value - ATT_W'(1);
`ifdef AGC_FAST_ATTACK_EN
        next_state = fast && next_value < i_max_att ? UPDATE : SETTLE;
`else
        next_state = SETTLE;
`endif
      end
      SETTLE: if (settle_done) begin
        // a ceiling still below the value chains straight into the next forced decrement
        next_state = i_max_att < o_agc_value ? UPDATE : MONITOR;
        next_dir = DEC;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      dir <= INC;
      hi_cnt <= '0;
      lo_cnt <= '0;
      o_agc_value <= '0;
      o_att_inc <= 1'b0;
      o_att_dec <= 1'b0;
      o_hold <= 1'b0;
    end else begin
      state <= next_state;
      dir <= next_dir;
      hi_cnt <= next_hi;
      lo_cnt <= next_lo;
      o_agc_value <= next_value;
      o_att_inc <= step && dir == INC;
      o_att_dec <= step && dir == DEC;
      o_hold <= next_state == SETTLE;
    end
  a_settle_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n) state == SETTLE |-> settle_busy);
endmodule

// File: tb/tb_agc_step_ctrl.sv
// tb_agc_step_ctrl: directed stimulus against a cycle-level behavioural model plus literal checks.
module tb_agc_step_ctrl;
  localparam int S = 20;
  localparam int A = 1;
  localparam int R = 4;
  logic clk = 1'b0;
  logic rst_n, agc_en, meas_vld, mcu_clr;
  logic [31:0] power_peak, high_gate, low_gate;
  logic [5:0] max_att, agc_value;
  logic att_inc, att_dec, hold;
  logic [1:0] state;
  int n_chk = 0, n_pass = 0, cyc_n = 0, obs_inc = 0, obs_dec = 0;
  int m_val = 0, m_hi = 0, m_lo = 0, m_pend = 0, m_hold = 0, m_idle = 1, m_inc = 0, m_dec = 0;
  bit m_up = 1'b0;
  int i0, d0, t1, t2, n;

  agc_step_ctrl #(.SETTLE_CNT(S), .ATTACK_N(A), .RELEASE_N(R)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_agc_en(agc_en), .i_meas_vld(meas_vld),
    .i_power_peak(power_peak), .i_high_gate(high_gate), .i_low_gate(low_gate),
    .i_max_att(max_att), .i_mcu_clr(mcu_clr), .o_agc_value(agc_value),
    .o_att_inc(att_inc), .o_att_dec(att_dec), .o_hold(hold), .o_state(state)
  );

  always #5 clk = ~clk;

  // Model: pending steps, remaining hold cycles and idle flag describe the loop behaviour.
  always @(posedge clk) begin
    m_inc = 0;
    m_dec = 0;
    if (!rst_n) begin
      m_val = 0; m_hi = 0; m_lo = 0; m_pend = 0; m_hold = 0; m_idle = 1;
    end else if (mcu_clr) begin
      m_val = 0; m_hi = 0; m_lo = 0; m_pend = 0;
      m_hold = agc_en ? S : 0;
      m_idle = agc_en ? 0 : 1;
    end else if (!agc_en) begin
      m_idle = 1; m_hold = 0; m_pend = 0; m_hi = 0; m_lo = 0;
    end else if (m_idle != 0) m_idle = 0;
    else if (m_pend > 0) begin
      if (m_up) begin m_val++; m_inc = 1; end
      else begin m_val--; m_dec = 1; end
      m_pend--;
      if (m_pend > 0 && m_val >= int'(max_att)) m_pend = 0;
      if (m_pend == 0) m_hold = S;
      m_hi = 0; m_lo = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        m_hi = 0; m_lo = 0;
        if (int'(max_att) < m_val) begin m_pend = 1; m_up = 1'b0; end
      end
    end else begin
      if (int'(max_att) < m_val) begin m_pend = 1; m_up = 1'b0; end
      else if (m_hi == A && m_val < int'(max_att)) begin m_pend = 1; m_up = 1'b1; end
      else if (m_lo == R && m_val > 0) begin m_pend = 1; m_up = 1'b0; end
`ifdef AGC_FAST_ATTACK_EN
      else if (meas_vld && longint'(power_peak) > 2 * longint'(high_gate) && m_val < int'(max_att)) begin
        m_pend = 2; m_up = 1'b1;
      end
`endif
      else if (meas_vld) begin
        if (power_peak > high_gate) begin m_hi = (m_hi < 15) ? m_hi + 1 : 15; m_lo = 0; end
        else if (power_peak < low_gate) begin m_lo = (m_lo < 15) ? m_lo + 1 : 15; m_hi = 0; end
        else begin m_hi = 0; m_lo = 0; end
      end
    end
  end

  always @(negedge clk) begin
    int m_state;
    m_state = (m_idle != 0) ? 0 : (m_pend > 0) ? 2 : (m_hold > 0) ? 3 : 1;
    cyc_n++;
    obs_inc += int'(att_inc);
    obs_dec += int'(att_dec);
    n_chk++;
    if (int'(agc_value) == m_val && int'(att_inc) == m_inc && int'(att_dec) == m_dec &&
        int'(hold) == int'(m_hold > 0) && int'(state) == m_state)
      n_pass++;
    else
      $display("FAIL model cyc %0d: got val=%0d inc=%0d dec=%0d hold=%0d st=%0d expected val=%0d inc=%0d dec=%0d hold=%0d st=%0d",
               cyc_n, agc_value, att_inc, att_dec, hold, state, m_val, m_inc, m_dec, m_hold > 0, m_state);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(input int k);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  task automatic strobe(input logic [31:0] p);
    meas_vld = 1'b1;
    power_peak = p;
    tick(1);
    meas_vld = 1'b0;
  endtask

  task automatic wait_dec(input string nm, output int t);
    int k = 0;
    while (!att_dec && k < 3 * S) begin tick(1); k++; end
    check(nm, int'(att_dec), 1);
    t = cyc_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; agc_en = 1'b0; meas_vld = 1'b0; mcu_clr = 1'b0;
    power_peak = 0; high_gate = 100; low_gate = 50; max_att = 63;
    tick(3);
    check("reset_value", int'(agc_value), 0);
    check("reset_state", int'(state), 0);
    check("reset_hold", int'(hold), 0);
    rst_n = 1'b1;
    tick(1);
    agc_en = 1'b1;
    tick(2);
    check("enter_monitor", int'(state), 1);
    strobe(200);
    tick(1);
    check("update_state", int'(state), 2);
    check("no_early_inc", int'(att_inc), 0);
    tick(1);
    check("inc_pulse", int'(att_inc), 1);
    check("value_1", int'(agc_value), 1);
    n = 0;
    while (hold && n < 100) begin n++; tick(1); end
    check("hold_length", n, S);
    check("back_to_monitor", int'(state), 1);
    strobe(200); tick(S + 3);
    strobe(200); tick(S + 3);
    check("value_3", int'(agc_value), 3);
    d0 = obs_dec;
    repeat (4) strobe(10);
    tick(S + 3);
    check("release_value", int'(agc_value), 2);
    check("release_pulses", obs_dec - d0, 1);
    d0 = obs_dec;
    repeat (3) strobe(10);
    strobe(75);
    strobe(100);
    repeat (3) strobe(10);
    tick(S + 3);
    check("inband_value", int'(agc_value), 2);
    check("inband_no_pulse", obs_dec - d0, 0);
    max_att = 5;
    repeat (3) begin strobe(200); tick(S + 3); end
    check("value_5", int'(agc_value), 5);
    i0 = obs_inc;
    repeat (4) strobe(200);
    tick(4);
    check("ceiling_value", int'(agc_value), 5);
    check("ceiling_no_pulse", obs_inc - i0, 0);
    max_att = 3;
    wait_dec("forced_dec_1", t1);
    tick(1);
    wait_dec("forced_dec_2", t2);
    check("forced_spacing", t2 - t1, S + 1);
    tick(S + 3);
    check("forced_value", int'(agc_value), 3);
    check("forced_monitor", int'(state), 1);
    max_att = 63;
    i0 = obs_inc;
    strobe(200);
    tick(6);
    strobe(200);
    strobe(200);
    tick(S + 10);
    check("settle_drop_value", int'(agc_value), 4);
    check("settle_drop_pulses", obs_inc - i0, 1);
    repeat (3) begin strobe(200); tick(S + 3); end
    check("value_7", int'(agc_value), 7);
    i0 = obs_inc;
    d0 = obs_dec;
    mcu_clr = 1'b1;
    tick(1);
    mcu_clr = 1'b0;
    check("clr_value", int'(agc_value), 0);
    check("clr_hold", int'(hold), 1);
    check("clr_state", int'(state), 3);
    tick(S + 3);
    check("clr_no_pulse", (obs_inc - i0) + (obs_dec - d0), 0);
    strobe(200);
    tick(5);
    agc_en = 1'b0;
    tick(1);
    check("en_off_state", int'(state), 0);
    check("en_off_value", int'(agc_value), 1);
    check("en_off_hold", int'(hold), 0);
`ifdef AGC_FAST_ATTACK_EN
    agc_en = 1'b1;
    mcu_clr = 1'b1;
    tick(1);
    mcu_clr = 1'b0;
    tick(S + 3);
    strobe(250);
    tick(2);
    check("fast_first", int'(att_inc), 1);
    tick(1);
    check("fast_second", int'(att_inc), 1);
    check("fast_value", int'(agc_value), 2);
    tick(S + 3);
    mcu_clr = 1'b1;
    max_att = 1;
    tick(1);
    mcu_clr = 1'b0;
    tick(S + 3);
    i0 = obs_inc;
    strobe(250);
    tick(S + 5);
    check("fast_cap_value", int'(agc_value), 1);
    check("fast_cap_pulses", obs_inc - i0, 1);
`endif
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
